decoder_2to4: RTL and testbench
===============================

Name: decoder_2to4

Overview:
Registered 2-to-4 one-hot decoder with enable. A 2-bit select is decoded into a 4-bit one-hot word, captured on the clock edge. All outputs are zero when disabled or in reset. Used as a small address/select decoder that drives chip-select style lines downstream.

Parameters:
ACTIVE_LOW_OUT, 0, when 1 every output bit is inverted (one-cold); reset and disabled value become 4'b1111
REG_OUT, 1, when 1 out is registered (1-cycle latency); when 0 out is combinational from en/in, and reset still forces the idle value

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  decode enable, active high
in  input  2  select value 0..3
out  output  4  one-hot decode; bit k set when en=1 and in==k

Behaviour:
- Reset: on a rising clk edge with rst_n=0, out is set to 4'b0000 (4'b1111 if ACTIVE_LOW_OUT=1). Reset has priority over en.
- Decode function:
  - en=1 gives out = 4'b0001 << in: in=0→0001, 1→0010, 2→0100, 3→1000.
  - en=0 gives out = 4'b0000.
  - Exactly zero or one bit is set at any time.
- Latency with REG_OUT=1:
  - out reflects the en/in sampled at the previous rising edge, so latency is 1 cycle.
  - Changes of in or en between edges have no effect until the next edge.
- Latency with REG_OUT=0:
  - out follows en/in combinationally, with zero latency.
  - A registered reset flag, cleared on the first edge with rst_n=1, forces the idle value while it is set.
- en deasserted mid-sweep: the next registered out is all zeros, regardless of in.
- Simultaneous en and in change: both are sampled on the same edge, and the new pair is decoded.
- Reset released mid-operation: the first edge with rst_n=1 samples en/in normally; there is no extra warm-up cycle.
- X/Z on in while en=1: no requirement. Verification does not drive X on in while en=1.

Optional Feature:
Macro DECODER_2TO4_VALID_EN.
- Defined:
  - Adds output out_valid (1 bit), a registered copy of en with the same latency as out.
  - out_valid is 0 in reset.
  - out_valid=1 guarantees out is one-hot.
- Not defined: port absent; the rest of the behaviour is unchanged.

Decomposition:
- Package decoder_2to4_pkg holds:
  - localparam SEL_W=2 and OUT_W=4.
  - localparam IDLE_OUT=4'b0000.
  - A typedef for the OUT_W-bit decoded word.
- One combinational sub-module, decoder_2to4_comb:
  - Pure en/in → one-hot logic.
  - The top wraps it with the output register, the reset, polarity inversion and the optional valid flag.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1, in=3 → out=0000 (and out_valid=0); release → next edge out=1000.
- Disabled: rst_n=1, en=0, sweep in=0..3 → out stays 0000 every cycle.
- Enabled sweep: en=1, in=0,1,2,3 on consecutive edges → out=0001,0010,0100,1000, each appearing one cycle after its in (REG_OUT=1).
- Disable after sweep: en=1, in=3, then en=0 → out 1000 then 0000 on the next edge; in toggling while en=0 keeps 0000.
- Reset mid-operation: en=1, in=2, out=0100, assert rst_n=0 for one edge → out=0000; release → next edge 0100 again.
- Polarity and comb variants: ACTIVE_LOW_OUT=1, en=1, in=1 → out=1101, en=0 → 1111; REG_OUT=0, en=1, in=2 → out=0100 in the same cycle.

Source files
------------

// File: rtl/decoder_2to4_pkg.sv
// Shared widths, idle value and decoded-word type for the 2-to-4 select decoder.
package decoder_2to4_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 4;

  typedef logic [OUT_W-1:0] out_word_t;

  localparam out_word_t IDLE_OUT = 4'b0000;

  // One-hot word with only bit 'sel' set.
  function automatic out_word_t decode_sel(input logic [SEL_W-1:0] sel);
    out_word_t w;
    w      = '0;
    w[sel] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/decoder_2to4_comb.sv
// Pure combinational enable/select to one-hot decode; no state, no polarity handling.
module decoder_2to4_comb
  import decoder_2to4_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] in,
  output out_word_t        dec
);

  always_comb begin
    // NOTE: default assignment first so every path drives dec and no latch is inferred.
    dec = IDLE_OUT;
    if (en) dec = decode_sel(in);
  end

endmodule

// File: rtl/decoder_2to4.sv
// Registered (or combinational) 2-to-4 one-hot decoder with optional one-cold output.
// Optional out_valid port is enabled by defining DECODER_2TO4_VALID_EN.
module decoder_2to4
  import decoder_2to4_pkg::*;
#(
  parameter bit ACTIVE_LOW_OUT = 1'b0,
  parameter bit REG_OUT        = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] in,
`ifdef DECODER_2TO4_VALID_EN
  output logic             out_valid,
`endif
  output logic [OUT_W-1:0] out
);

  out_word_t dec_word;
  out_word_t word;

  decoder_2to4_comb u_comb (
    .en  (en),
    .in  (in),
    .dec (dec_word)
  );

  if (REG_OUT) begin : g_reg
    out_word_t word_q;
`ifdef DECODER_2TO4_VALID_EN
    logic valid_q;
`endif

    // NOTE: reset is synchronous (sampled on the edge) and state updates use <= only.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        word_q <= IDLE_OUT;
`ifdef DECODER_2TO4_VALID_EN
        valid_q <= 1'b0;
`endif
      end else begin
        word_q <= dec_word;
`ifdef DECODER_2TO4_VALID_EN
        valid_q <= en;
`endif
      end
    end

    assign word = word_q;
`ifdef DECODER_2TO4_VALID_EN
    assign out_valid = valid_q;
`endif
  end else begin : g_comb
    // Set while the last edge saw reset; holds the output idle until the first clean edge.
    logic rst_flag;

    always_ff @(posedge clk) begin
      rst_flag <= !rst_n;
    end

    assign word = rst_flag ? IDLE_OUT : dec_word;
`ifdef DECODER_2TO4_VALID_EN
    assign out_valid = en && !rst_flag;
`endif
  end

  // Inverting the idle word also yields the one-cold reset/disabled value 4'b1111.
  assign out = ACTIVE_LOW_OUT ? ~word : word;

endmodule

// File: tb/tb_decoder_2to4.sv
// Scoreboard bench for decoder_2to4: registered, one-cold and combinational variants.
module tb_decoder_2to4;

  typedef struct {
    logic [3:0] word;
    logic       valid;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;

  logic [3:0] out_reg, out_lo, out_cmb;
`ifdef DECODER_2TO4_VALID_EN
  logic       v_reg, v_lo, v_cmb;
`endif

  exp_t q_reg[$];
  exp_t q_cmb[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  last_edge_reset = 1'b1;

  always #5 clk = ~clk;

  decoder_2to4 #(.ACTIVE_LOW_OUT(1'b0), .REG_OUT(1'b1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .en(en), .in(sel),
`ifdef DECODER_2TO4_VALID_EN
    .out_valid(v_reg),
`endif
    .out(out_reg)
  );

  decoder_2to4 #(.ACTIVE_LOW_OUT(1'b1), .REG_OUT(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .in(sel),
`ifdef DECODER_2TO4_VALID_EN
    .out_valid(v_lo),
`endif
    .out(out_lo)
  );

  decoder_2to4 #(.ACTIVE_LOW_OUT(1'b0), .REG_OUT(1'b0)) dut_cmb (
    .clk(clk), .rst_n(rst_n), .en(en), .in(sel),
`ifdef DECODER_2TO4_VALID_EN
    .out_valid(v_cmb),
`endif
    .out(out_cmb)
  );

  // Reference: enabled select k lights the bit of weight 2**k; anything else is dark.
  function automatic logic [3:0] ref_word(input bit active, input bit e, input int s);
    if (!active || !e) return 4'd0;
    return 4'(2 ** s);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Registered variants: what the edge samples is what appears after it.
  always @(posedge clk) begin
    exp_t e;
    e.word  = ref_word(rst_n, en, int'(sel));
    e.valid = rst_n && en;
    q_reg.push_back(e);
    last_edge_reset = !rst_n;
  end

  // Drive one cycle of stimulus on the falling edge; the comb variant answers immediately.
  task automatic drive(input bit r, input bit e, input logic [1:0] s);
    exp_t x;
    @(negedge clk);
    rst_n = r;
    en    = e;
    sel   = s;
    x.word  = ref_word(!last_edge_reset, e, int'(s));
    x.valid = e && !last_edge_reset;
    q_cmb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q_reg.size() > 0) begin
      e = q_reg.pop_front();
      check("reg_out", out_reg, e.word);
      check("lo_out", out_lo, ~e.word);
`ifdef DECODER_2TO4_VALID_EN
      check("reg_valid", {3'b0, v_reg}, {3'b0, e.valid});
      check("lo_valid", {3'b0, v_lo}, {3'b0, e.valid});
`endif
    end
    if (q_cmb.size() > 0) begin
      e = q_cmb.pop_front();
      check("cmb_out", out_cmb, e.word);
`ifdef DECODER_2TO4_VALID_EN
      check("cmb_valid", {3'b0, v_cmb}, {3'b0, e.valid});
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    sel   = 2'd3;

    // Reset held two edges with en=1/in=3, then release.
    drive(1'b0, 1'b1, 2'd3);
    drive(1'b1, 1'b1, 2'd3);
    drive(1'b1, 1'b1, 2'd3);

    // Disabled sweep.
    for (int s = 0; s < 4; s++) drive(1'b1, 1'b0, 2'(s));

    // Enabled sweep.
    for (int s = 0; s < 4; s++) drive(1'b1, 1'b1, 2'(s));

    // Disable after sweep, select toggling while disabled.
    drive(1'b1, 1'b1, 2'd3);
    drive(1'b1, 1'b0, 2'd3);
    drive(1'b1, 1'b0, 2'd1);
    drive(1'b1, 1'b0, 2'd2);

    // Reset mid-operation for one edge, then back to the same select.
    drive(1'b1, 1'b1, 2'd2);
    drive(1'b1, 1'b1, 2'd2);
    drive(1'b0, 1'b1, 2'd2);
    drive(1'b1, 1'b1, 2'd2);
    drive(1'b1, 1'b1, 2'd2);

    // Simultaneous en/in changes and random traffic with occasional reset.
    drive(1'b1, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 2'd1);
    drive(1'b1, 1'b0, 2'd3);
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));

    drive(1'b1, 1'b0, 2'd0);
    @(negedge clk);
    #3;
    check("reg_queue_drained", 4'(q_reg.size()), 4'd0);
    check("cmb_queue_drained", 4'(q_cmb.size()), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
